// File: rtl/axil_sim_memory.sv
// AXI4-Lite simulation memory with console and pass/fail registers.
// Read pipeline with programmable latency; independent AW/W capture.
module axil_sim_memory #(
    parameter int          DATA_W       = 32,
    parameter int          MEM_BYTES    = 65536,
    parameter int          RD_LATENCY   = 1,
    parameter int          RQ_DEPTH     = 4,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [31:0]         s_awaddr,
    input  logic [2:0]          s_awprot,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [31:0]         s_araddr,
    input  logic [2:0]          s_arprot,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                console_valid,
    output logic [7:0]          console_data,
    output logic                tests_passed,
    output logic                err_valid,
    output logic [31:0]         err_addr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_HI = $clog2(MEM_BYTES);
    localparam int WORDS  = MEM_BYTES / STRB_W;
    localparam int PTR_W  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RQ_DEPTH + 1);

    localparam logic [31:0]      MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RQ_DEPTH - 1);
    localparam logic [CNT_W-1:0] RQ_FULL_N = CNT_W'(RQ_DEPTH);
    localparam logic [3:0]       LAT_INIT  = 4'(RD_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [WORDS];

    logic unused_prot;
    assign unused_prot = ^{s_awprot, s_arprot};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ---------------- read queue ----------------
    logic [31:0]           rq_addr [RQ_DEPTH];
    logic [3:0]            rq_cnt  [RQ_DEPTH];
    logic [PTR_W-1:0]      rq_rd;
    logic [PTR_W-1:0]      rq_wr;
    logic [CNT_W-1:0]      rq_count;
    logic                  rq_push;
    logic                  rq_pop;
    logic [31:0]           head_addr;
    logic                  head_oob;
    logic [IDX_HI-LSB-1:0] head_idx;

    assign s_arready = (rq_count != RQ_FULL_N);
    assign rq_push   = s_arvalid && s_arready;
    assign head_addr = rq_addr[rq_rd];
    assign head_oob  = (head_addr >= MEM_LIMIT);
    assign head_idx  = head_addr[IDX_HI-1:LSB];
    assign rq_pop    = (rq_count != '0) && (rq_cnt[rq_rd] == 4'd0)
                    && (!s_rvalid || s_rready);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rq_rd    <= '0;
            rq_wr    <= '0;
            rq_count <= '0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < RQ_DEPTH; i++) begin
                if (rq_cnt[i] != 4'd0) begin
                    rq_cnt[i] <= rq_cnt[i] - 4'd1;
                end
            end
            // the freshly pushed slot overrides the decrement above
            if (rq_push) begin
                rq_addr[rq_wr] <= s_araddr;
                rq_cnt[rq_wr]  <= LAT_INIT;
                rq_wr          <= ptr_inc(rq_wr);
            end
            if (rq_pop) begin
                rq_rd <= ptr_inc(rq_rd);
            end
            rq_count <= rq_count + CNT_W'(rq_push) - CNT_W'(rq_pop);
        end
    end

    // ---------------- R output register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (rq_pop) begin
            s_rvalid <= 1'b1;
            s_rresp  <= head_oob ? RESP_SLVERR : RESP_OKAY;
            s_rdata  <= head_oob ? '0 : mem[head_idx];
        end else if (s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    // ---------------- write path ----------------
    logic                  aw_held;
    logic                  w_held;
    logic [31:0]           aw_addr;
    logic [DATA_W-1:0]     w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  commit;
    logic                  wr_con;
    logic                  wr_pass;
    logic                  wr_err;
    logic                  mem_we;
    logic [IDX_HI-LSB-1:0] aw_idx;

    assign s_awready = !aw_held;
    assign s_wready  = !w_held;
    assign commit    = aw_held && w_held && (!s_bvalid || s_bready);
    assign aw_idx    = aw_addr[IDX_HI-1:LSB];

    always_comb begin
        wr_con  = 1'b0;
        wr_pass = 1'b0;
        wr_err  = 1'b0;
        if (aw_addr == CONSOLE_ADDR) begin
            wr_con = 1'b1;
        end else if (aw_addr == PASS_ADDR) begin
            wr_pass = 1'b1;
        end else if (aw_addr >= MEM_LIMIT) begin
            wr_err = 1'b1;
        end
    end

    assign mem_we = resetn && commit && !wr_con && !wr_pass && !wr_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_bvalid      <= 1'b0;
            s_bresp       <= RESP_OKAY;
            console_valid <= 1'b0;
            console_data  <= '0;
            tests_passed  <= 1'b0;
        end else begin
            console_valid <= 1'b0;
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (wr_con) begin
                    console_valid <= 1'b1;
                    console_data  <= w_data[7:0];
                end
                if (wr_pass && (w_data[31:0] == PASS_VALUE)) begin
                    tests_passed <= 1'b1;
                end
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // memory contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- first-error capture ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (!err_valid) begin
            if (rq_pop && head_oob) begin
                err_valid <= 1'b1;
                err_addr  <= head_addr;
            end else if (commit && wr_err) begin
                err_valid <= 1'b1;
                err_addr  <= aw_addr;
            end
        end
    end

endmodule

// File: tb/tb_axil_sim_memory.sv
// Self-checking bench for axil_sim_memory (RD_LATENCY=3, RQ_DEPTH=2).
// Directed protocol steps plus random traffic against a word-array model.
module tb_axil_sim_memory;

    localparam logic [31:0] CON_A  = 32'h1000_0000;
    localparam logic [31:0] PASS_A = 32'h2000_0000;
    localparam logic [31:0] PASS_V = 32'd123456789;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        tests_passed;
    logic        err_valid;
    logic [31:0] err_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int cons_cnt = 0;
    logic [7:0] cons_last = 8'h00;

    logic [31:0] ref_mem [int];

    axil_sim_memory #(
        .DATA_W(32), .MEM_BYTES(65536), .RD_LATENCY(3), .RQ_DEPTH(2),
        .CONSOLE_ADDR(CON_A), .PASS_ADDR(PASS_A), .PASS_VALUE(PASS_V)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .console_valid(console_valid), .console_data(console_data),
        .tests_passed(tests_passed),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (console_valid) begin
            cons_cnt  = cons_cnt + 1;
            cons_last = console_data;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[15:2]);
    endfunction

    // model update: only in-range, non-special addresses touch memory
    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        if (a != CON_A && a != PASS_A && a < 32'h0001_0000)
            ref_mem[widx(a)] = merge(ref_mem.exists(widx(a)) ?
                                     ref_mem[widx(a)] : 32'h0, d, s);
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        bit aw_go, w_go, b_done;
        aw_go = 0; w_go = 0; b_done = 0; resp = 2'bxx;
        s_awvalid = 1; s_awaddr = a;
        s_wvalid = 1; s_wdata = d; s_wstrb = s; s_bready = 1;
        for (int t = 0; t < 40 && !b_done; t++) begin
            @(negedge clk);
            if (s_awvalid && s_awready) aw_go = 1;
            if (s_wvalid && s_wready) w_go = 1;
            if (s_bvalid) begin
                b_done = 1;
                resp = s_bresp;
            end
            tick();
            if (aw_go) s_awvalid = 0;
            if (w_go) s_wvalid = 0;
        end
        s_awvalid = 0; s_wvalid = 0;
        chk("wr_complete", 64'(b_done), 64'd1);
        model_write(a, d, s);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
        bit ar_go, got;
        ar_go = 0; got = 0; d = 'x; resp = 2'bxx;
        s_arvalid = 1; s_araddr = a; s_rready = 1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (s_arvalid && s_arready) ar_go = 1;
            if (s_rvalid) begin
                got = 1;
                d = s_rdata;
                resp = s_rresp;
            end
            tick();
            if (ar_go) s_arvalid = 0;
        end
        s_arvalid = 0;
        chk("rd_complete", 64'(got), 64'd1);
    endtask

    task automatic check_idle(input string p);
        chk({p, "_arready"}, 64'(s_arready), 64'd1);
        chk({p, "_awready"}, 64'(s_awready), 64'd1);
        chk({p, "_wready"}, 64'(s_wready), 64'd1);
        chk({p, "_rvalid"}, 64'(s_rvalid), 64'd0);
        chk({p, "_bvalid"}, 64'(s_bvalid), 64'd0);
        chk({p, "_passed"}, 64'(tests_passed), 64'd0);
        chk({p, "_errv"}, 64'(err_valid), 64'd0);
        chk({p, "_erra"}, 64'(err_addr), 64'd0);
        chk({p, "_rdata"}, 64'(s_rdata), 64'd0);
        chk({p, "_rresp"}, 64'(s_rresp), 64'd0);
        chk({p, "_bresp"}, 64'(s_bresp), 64'd0);
        chk({p, "_cons"}, 64'(console_valid), 64'd0);
    endtask

    initial begin
        logic [1:0]  rsp;
        logic [31:0] rd;
        logic [31:0] d0, d1, d2;
        logic [31:0] exp_q [$];
        logic [31:0] addrs [$];
        int          issued, recv, c0;
        bit          ar_hs, r_hs;

        resetn = 0;
        s_awvalid = 0; s_awaddr = 0; s_awprot = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
        s_arvalid = 0; s_araddr = 0; s_arprot = 0; s_rready = 0;
        repeat (3) tick();
        resetn = 1;
        check_idle("rst");

        // preload through the bus
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        do_write(32'h0, 32'h0BAD_F00D, 4'hF, rsp);
        do_write(32'h10, 32'hCAFE_BABE, 4'hF, rsp);
        chk("pre_bresp", 64'(rsp), 64'd0);
        do_write(32'h20, 32'h1122_3344, 4'hF, rsp);
        do_write(32'h30, 32'h5566_7788, 4'hF, rsp);
        do_write(32'h40, d0, 4'hF, rsp);
        do_write(32'h44, d1, 4'hF, rsp);
        do_write(32'h48, d2, 4'hF, rsp);
        do_write(32'h50, 32'h0F0F_0F0F, 4'hF, rsp);
        for (int i = 0; i < 64; i++)
            do_write(32'h100 + 32'(i * 4), $urandom, 4'hF, rsp);

        // read latency 3
        s_araddr = 32'h10; s_arvalid = 1; s_rready = 1;
        chk("lat_arready", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 0;
        chk("lat_t1", 64'(s_rvalid), 64'd0);
        tick();
        chk("lat_t2", 64'(s_rvalid), 64'd0);
        tick();
        chk("lat_t3_nvalid", 64'(s_rvalid), 64'd0);
        tick();
        chk("lat_rvalid", 64'(s_rvalid), 64'd1);
        chk("lat_rdata", 64'(s_rdata), 64'(ref_mem[widx(32'h10)]));
        chk("lat_rresp", 64'(s_rresp), 64'd0);
        tick();
        chk("lat_drain", 64'(s_rvalid), 64'd0);

        // queue back-pressure with rready low
        s_rready = 0; s_arvalid = 1; s_araddr = 32'h40;
        chk("bp_ar0", 64'(s_arready), 64'd1);
        tick();
        s_araddr = 32'h44;
        chk("bp_ar1", 64'(s_arready), 64'd1);
        tick();
        s_araddr = 32'h48;
        chk("bp_full", 64'(s_arready), 64'd0);
        tick();
        chk("bp_stall", 64'(s_arready), 64'd0);
        chk("bp_norv", 64'(s_rvalid), 64'd0);
        tick();
        chk("bp_rv", 64'(s_rvalid), 64'd1);
        chk("bp_rd0", 64'(s_rdata), 64'(ref_mem[widx(32'h40)]));
        while (!s_arready && c0 < 20) begin
            tick();
            c0++;
        end
        tick();
        s_arvalid = 0;
        chk("bp_hold", 64'(s_rdata), 64'(ref_mem[widx(32'h40)]));
        exp_q = '{d0, d1, d2};
        s_rready = 1;
        recv = 0;
        for (int t = 0; t < 30 && recv < 3; t++) begin
            @(negedge clk);
            if (s_rvalid) begin
                chk("bp_order", 64'(s_rdata), 64'(exp_q.pop_front()));
                recv++;
            end
            tick();
        end
        chk("bp_count", 64'(recv), 64'd3);

        // W two cycles ahead of AW, single byte lane
        s_bready = 0; s_wvalid = 1;
        s_wdata = 32'hAABB_CCDD; s_wstrb = 4'b0010;
        chk("wf_wready", 64'(s_wready), 64'd1);
        tick();
        s_wvalid = 0;
        chk("wf_wheld", 64'(s_wready), 64'd0);
        chk("wf_nob0", 64'(s_bvalid), 64'd0);
        tick();
        s_awvalid = 1; s_awaddr = 32'h20;
        chk("wf_awready", 64'(s_awready), 64'd1);
        tick();
        s_awvalid = 0;
        chk("wf_nob2", 64'(s_bvalid), 64'd0);
        tick();
        chk("wf_bvalid", 64'(s_bvalid), 64'd1);
        chk("wf_bresp", 64'(s_bresp), 64'd0);
        tick();
        chk("wf_bhold", 64'(s_bvalid), 64'd1);
        s_bready = 1;
        tick();
        chk("wf_bdrain", 64'(s_bvalid), 64'd0);
        model_write(32'h20, 32'hAABB_CCDD, 4'b0010);
        do_read(32'h20, rd, rsp);
        chk("wf_readback", 64'(rd), 64'(ref_mem[widx(32'h20)]));

        // zero strobe leaves memory untouched
        do_write(32'h50, 32'hFFFF_FFFF, 4'h0, rsp);
        chk("z_bresp", 64'(rsp), 64'd0);
        do_read(32'h50, rd, rsp);
        chk("z_data", 64'(rd), 64'(ref_mem[widx(32'h50)]));

        // console and pass registers
        c0 = cons_cnt;
        do_write(CON_A, 32'h0000_0041, 4'hF, rsp);
        chk("con_bresp", 64'(rsp), 64'd0);
        chk("con_pulses", 64'(cons_cnt - c0), 64'd1);
        chk("con_data", 64'(cons_last), 64'h41);
        do_write(PASS_A, PASS_V + 32'd1, 4'hF, rsp);
        chk("pass_wrong", 64'(tests_passed), 64'd0);
        do_write(PASS_A, PASS_V, 4'hF, rsp);
        chk("pass_bresp", 64'(rsp), 64'd0);
        chk("pass_set", 64'(tests_passed), 64'd1);

        // out-of-bounds
        do_read(32'h0001_0000, rd, rsp);
        chk("oob_rresp", 64'(rsp), 64'd2);
        chk("oob_rdata", 64'(rd), 64'd0);
        chk("oob_errv", 64'(err_valid), 64'd1);
        chk("oob_erra", 64'(err_addr), 64'h0001_0000);
        do_write(32'h0002_0000, 32'h1234_5678, 4'hF, rsp);
        chk("oobw_bresp", 64'(rsp), 64'd2);
        chk("oobw_erra", 64'(err_addr), 64'h0001_0000);
        do_read(32'h0, rd, rsp);
        chk("oobw_noalias", 64'(rd), 64'(ref_mem[0]));

        // random partial writes then pipelined random reads
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 63) * 4);
            do_write(a, $urandom, 4'($urandom_range(0, 15)), rsp);
            chk("rnd_bresp", 64'(rsp), 64'd0);
        end
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 63) * 4)
              + 32'($urandom_range(0, 3));
            addrs.push_back(a);
            exp_q.push_back(ref_mem[widx(a)]);
        end
        issued = 0; recv = 0;
        for (int c = 0; c < 600 && recv < 30; c++) begin
            s_arvalid = (issued < 30);
            if (issued < 30) s_araddr = addrs[issued];
            s_rready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs = s_rvalid && s_rready;
            if (r_hs) begin
                chk("rnd_rdata", 64'(s_rdata), 64'(exp_q.pop_front()));
                recv++;
            end
            tick();
            if (ar_hs) issued++;
        end
        s_arvalid = 0; s_rready = 0;
        chk("rnd_rcount", 64'(recv), 64'd30);

        // reset with AW held, W pending and two reads queued
        s_arvalid = 1; s_araddr = 32'h100;
        tick();
        s_araddr = 32'h104;
        tick();
        s_arvalid = 0;
        s_awvalid = 1; s_awaddr = 32'h30;
        tick();
        s_awvalid = 0;
        s_wvalid = 1; s_wdata = 32'hDEAD_0000; s_wstrb = 4'hF;
        resetn = 0;
        tick();
        tick();
        s_wvalid = 0;
        resetn = 1;
        check_idle("mid");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_norv", 64'(s_rvalid), 64'd0);
            chk("mid_nobv", 64'(s_bvalid), 64'd0);
        end
        do_read(32'h30, rd, rsp);
        chk("mid_word", 64'(rd), 64'(ref_mem[widx(32'h30)]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
